pattern_detect_ctrl: RTL and testbench

//   Programmable serial pattern-detection controller. Replaces fixed-pattern

---
 rtl/pattern_detect_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_pattern_detect_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_detect_ctrl.sv
// Programmable serial pattern detector with match counting and target stop.
// Optional idle-bit timeout is built when PDC_TIMEOUT_EN is defined.
module pattern_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int TMO_W   = 10,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  output logic               cfg_err,
  input  logic               start,
  input  logic               abort,
  input  logic               din_valid,
  input  logic               din,
  output logic               din_ready,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state, state_n;

  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;
  logic [CNT_W-1:0]   tgt_r;

  logic [MAX_LEN-1:0] hist, hist_n;
  logic [LEN_W-1:0]   hcnt, hcnt_n;
  logic [CNT_W-1:0]   mcnt_n;
  logic               match_n;
  logic               done_n;
  logic               cfg_err_n;

  logic [MAX_LEN-1:0] nh;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     hcnt_p1;
  logic [CNT_W:0]     mcnt_p1;
  logic               acc;
  logic               hit;
  logic               last;
  logic               idle_or_done;
  logic               len_ok;
  logic               cfg_ok;

  assign busy      = (state == RUN);
  assign din_ready = busy;

  assign idle_or_done = (state == IDLE) || (state == DONE);
  assign len_ok = (cfg_len != '0) &&
                  (cfg_len <= LEN_W'(MAX_LEN));
  assign cfg_ok = cfg_we && idle_or_done && len_ok;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      mask[i] = (i < int'(len_r));
  end

  assign acc     = din_valid && busy;
  assign nh      = {hist[MAX_LEN-2:0], din};
  assign hcnt_p1 = {1'b0, hcnt} + 1'b1;
  assign hit     = acc &&
                   (hcnt_p1 >= {1'b0, len_r}) &&
                   ((nh & mask) == (pat_r & mask));
  assign mcnt_p1 = {1'b0, match_cnt} + 1'b1;
  assign last    = hit && (tgt_r != '0) &&
                   (mcnt_p1 == {1'b0, tgt_r});

`ifdef PDC_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;
  logic             tmo_n;
`endif

  always_comb begin
    state_n   = state;
    hist_n    = hist;
    hcnt_n    = hcnt;
    mcnt_n    = match_cnt;
    match_n   = 1'b0;
    done_n    = done;
    cfg_err_n = cfg_we && !cfg_ok;
`ifdef PDC_TIMEOUT_EN
    tmo_cnt_n = tmo_cnt;
    tmo_n     = timeout;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
          hist_n  = '0;
          hcnt_n  = '0;
          mcnt_n  = '0;
          done_n  = 1'b0;
`ifdef PDC_TIMEOUT_EN
          tmo_cnt_n = '0;
          tmo_n     = 1'b0;
`endif
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (acc) begin
          hist_n = nh;
          // Non-overlap restarts the fill count so no bit is reused
          if (hit && !ovl_r)
            hcnt_n = '0;
          else if (hcnt_p1 > (LEN_W+1)'(MAX_LEN))
            hcnt_n = LEN_W'(MAX_LEN);
          else
            hcnt_n = hcnt_p1[LEN_W-1:0];
          if (hit) begin
            match_n = 1'b1;
            if (!mcnt_p1[CNT_W])
              mcnt_n = mcnt_p1[CNT_W-1:0];
          end
          if (last) begin
            state_n = DONE;
            done_n  = 1'b1;
          end
`ifdef PDC_TIMEOUT_EN
          if (hit) begin
            tmo_cnt_n = '0;
          end else begin
            tmo_cnt_n = tmo_cnt + 1'b1;
            if (&tmo_cnt_n) begin
              state_n = DONE;
              done_n  = 1'b1;
              tmo_n   = 1'b1;
            end
          end
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hist      <= '0;
      hcnt      <= '0;
      match_cnt <= '0;
      match     <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_n;
      hist      <= hist_n;
      hcnt      <= hcnt_n;
      match_cnt <= mcnt_n;
      match     <= match_n;
      done      <= done_n;
      cfg_err   <= cfg_err_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_r <= '0;
      len_r <= LEN_W'(MAX_LEN);
      ovl_r <= 1'b0;
      tgt_r <= '0;
    end else if (cfg_ok) begin
      pat_r <= cfg_pattern;
      len_r <= cfg_len;
      ovl_r <= cfg_overlap;
      tgt_r <= cfg_target;
    end
  end

`ifdef PDC_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      tmo_cnt <= tmo_cnt_n;
      timeout <= tmo_n;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Scoreboard bench for pattern_detect_ctrl.
// Expected matches are queued by stimulus and popped by the match monitor.
module tb_pattern_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_target;
  logic       cfg_err;
  logic       start;
  logic       abort;
  logic       din_valid;
  logic       din;
  logic       din_ready;
  logic       match;
  logic [7:0] match_cnt;
  logic       busy;
  logic       done;
  logic       timeout;

  typedef struct {
    int bit_no;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   sent_no = 0;

  pattern_detect_ctrl #(
    .MAX_LEN(8),
    .CNT_W  (8),
    .TMO_W  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cfg_target (cfg_target),
    .cfg_err    (cfg_err),
    .start      (start),
    .abort      (abort),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .match      (match),
    .match_cnt  (match_cnt),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    checks++;
    if (act == exp)
      passes++;
    else
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
  endtask

  always @(negedge clk) begin
    if (match === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_match actual=bit%0d required=none",
                 sent_no);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("match_bit", sent_no, e.bit_no);
        chk("match_cnt_at_pulse", int'(match_cnt), e.cnt);
      end
    end
  end

  task automatic cfg(input logic [7:0] p,
                     input logic [3:0] l,
                     input logic o,
                     input logic [7:0] t);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cfg_target  = t;
    cfg_we      = 1'b1;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic pulse_abort;
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
  endtask

  task automatic send(input logic b, input int n);
    din       = b;
    din_valid = 1'b1;
    @(posedge clk);
    #1 sent_no = n;
    din_valid = 1'b0;
  endtask

  task automatic exp_match(input int n, input int c);
    exp_q.push_back('{n, c});
  endtask

  task automatic settle;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  logic s1 [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1;
    cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; cfg_target = '0;
    start = 1'b0; abort = 1'b0;
    din_valid = 1'b0; din = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", din_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cfg_err", cfg_err, 0);

    // T1 non-overlap
    @(posedge clk); #1;
    cfg(8'b1001, 4'd4, 1'b0, 8'd0);
    pulse_start();
    chk("t1_busy", busy, 1);
    exp_match(4, 1);
    for (int i = 0; i < 7; i++) send(s1[i], i + 1);
    settle();
    chk("t1_cnt", match_cnt, 1);
    chk("t1_q", exp_q.size(), 0);

    // T2 overlap
    pulse_abort();
    cfg(8'b1001, 4'd4, 1'b1, 8'd0);
    pulse_start();
    chk("t2_cnt_clr", match_cnt, 0);
    exp_match(4, 1);
    exp_match(7, 2);
    for (int i = 0; i < 7; i++) send(s1[i], i + 1);
    settle();
    chk("t2_cnt", match_cnt, 2);
    chk("t2_q", exp_q.size(), 0);

    // T3 target stop
    pulse_abort();
    cfg(8'b11, 4'd2, 1'b0, 8'd3);
    pulse_start();
    exp_match(2, 1);
    exp_match(4, 2);
    exp_match(6, 3);
    for (int i = 1; i <= 8; i++) send(1'b1, i);
    settle();
    chk("t3_done", done, 1);
    chk("t3_ready", din_ready, 0);
    chk("t3_busy", busy, 0);
    chk("t3_cnt", match_cnt, 3);
    chk("t3_q", exp_q.size(), 0);
    cfg(8'h01, 4'd1, 1'b0, 8'd0);
    @(negedge clk);
    chk("t3_cfg_done_kept", done, 1);
    chk("t3_cfg_ok", cfg_err, 0);

    // T4 abort priority and config rejection
    @(posedge clk); #1;
    pulse_start();
    chk("t4_done_clr", done, 0);
    chk("t4_cnt_clr", match_cnt, 0);
    exp_match(1, 1);
    send(1'b1, 1);
    abort = 1'b1; start = 1'b1;
    din = 1'b1; din_valid = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0; start = 1'b0; din_valid = 1'b0;
    settle();
    chk("t4_abort_idle", busy, 0);
    chk("t4_cnt_kept", match_cnt, 1);
    @(posedge clk); #1;
    pulse_start();
    cfg(8'h00, 4'd2, 1'b0, 8'd0);
    @(negedge clk);
    chk("t4_err_run", cfg_err, 1);
    @(posedge clk); #1;
    pulse_abort();
    pulse_start();
    exp_match(1, 1);
    send(1'b1, 1);
    settle();
    chk("t4_cfg_unchanged", match_cnt, 1);
    @(posedge clk); #1;
    pulse_abort();
    cfg(8'h00, 4'd0, 1'b0, 8'd0);
    @(negedge clk);
    chk("t4_err_len0", cfg_err, 1);
    @(posedge clk); #1;
    cfg(8'h00, 4'd9, 1'b0, 8'd0);
    @(negedge clk);
    chk("t4_err_len9", cfg_err, 1);
    @(negedge clk);
    chk("t4_err_pulse_end", cfg_err, 0);
    chk("t4_q", exp_q.size(), 0);

    // T5 async reset mid-bit
    @(posedge clk); #1;
    pulse_start();
    exp_match(1, 1);
    send(1'b1, 1);
    @(posedge clk);
    #1 din = 1'b1; din_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_ready", din_ready, 0);
    chk("t5_cnt", match_cnt, 0);
    chk("t5_match", match, 0);
    @(posedge clk);
    #1 rst = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    chk("t5_idle", busy, 0);
    chk("t5_q", exp_q.size(), 0);

    // T6 idle-bit timeout
    @(posedge clk); #1;
    cfg(8'b11, 4'd2, 1'b0, 8'd0);
    pulse_start();
    for (int i = 1; i <= 14; i++) send(1'b0, i);
    @(negedge clk);
    chk("t6_not_yet", done, 0);
    @(posedge clk); #1;
    send(1'b0, 15);
    @(negedge clk);
`ifdef PDC_TIMEOUT_EN
    chk("t6_done", done, 1);
    chk("t6_timeout", timeout, 1);
    chk("t6_busy", busy, 0);
`else
    chk("t6_done", done, 0);
    chk("t6_timeout", timeout, 0);
    chk("t6_busy", busy, 1);
`endif
    settle();
    chk("final_q", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
